// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter,
// registered one-cycle rise/fall pulses and sticky event flags with clear.
module edge_detector_mc #(
  parameter int              CH          = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILTER_CNT  = 4,
  parameter logic [CH-1:0]   INIT_LEVEL  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] in,
  input  logic [CH-1:0] rise_en,
  input  logic [CH-1:0] fall_en,
  input  logic [CH-1:0] clr,
  output logic [CH-1:0] level,
  output logic [CH-1:0] raising,
  output logic [CH-1:0] falling,
  output logic [CH-1:0] rise_flag,
  output logic [CH-1:0] fall_flag,
  output logic          any_event
);

  // Counter only needs to reach FILTER_CNT-1; sized so FILTER_CNT=1 still has one bit.
  localparam int            CW      = $clog2(FILTER_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      logic [CW-1:0]          cnt_reg;
      logic                   level_reg;
      logic                   raising_reg;
      logic                   falling_reg;
      logic                   rise_flag_reg;
      logic                   fall_flag_reg;
      logic                   commit;
      logic                   rise_set;
      logic                   fall_set;

      if (SYNC_STAGES == 1) begin : g_sync_single
        // Single-flop synchroniser
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg <= INIT_LEVEL[gi];
          else        sync_reg <= in[gi];
        end
      end else begin : g_sync_chain
        // Shift chain: bit 0 samples the raw input, the top bit feeds the filter
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg <= {SYNC_STAGES{INIT_LEVEL[gi]}};
          else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
        end
      end

      assign s        = sync_reg[SYNC_STAGES-1];
      // A new level is committed on the FILTER_CNT-th consecutive mismatching sample.
      assign commit   = (s != level_reg) && (cnt_reg == CNT_MAX);
      assign rise_set = commit &  s & rise_en[gi];
      assign fall_set = commit & ~s & fall_en[gi];

      // Stability filter: any return to the committed level restarts the count
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          level_reg <= INIT_LEVEL[gi];
        end else if (s == level_reg) begin
          cnt_reg   <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          cnt_reg   <= '0;
          level_reg <= s;
        end else begin
          cnt_reg   <= cnt_reg + 1'b1;
        end
      end

      // Pulses and sticky flags; a set in the same cycle as clr takes priority
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          raising_reg   <= 1'b0;
          falling_reg   <= 1'b0;
          rise_flag_reg <= 1'b0;
          fall_flag_reg <= 1'b0;
        end else begin
          raising_reg   <= rise_set;
          falling_reg   <= fall_set;
          rise_flag_reg <= (rise_flag_reg & ~clr[gi]) | rise_set;
          fall_flag_reg <= (fall_flag_reg & ~clr[gi]) | fall_set;
        end
      end

      assign level[gi]     = level_reg;
      assign raising[gi]   = raising_reg;
      assign falling[gi]   = falling_reg;
      assign rise_flag[gi] = rise_flag_reg;
      assign fall_flag[gi] = fall_flag_reg;
    end
  endgenerate

  assign any_event = |(rise_flag | fall_flag);

endmodule
